// File: rtl/max7219_driver.sv
// MAX7219 3-wire serialiser: init command set after reset, then one frame per digit on each accepted update.
// Optional MAX7219_REFRESH_EN: after REFRESH_CYCLES idle cycles the init and digit frames are resent.
module max7219_driver #(
   parameter int unsigned CLK_DIV        = 2,
   parameter int unsigned NUM_DIGITS     = 8,
   parameter logic [3:0]  INTENSITY      = 4'h8,
   parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7*NUM_DIGITS-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    update,
   output logic                    ready,
   output logic                    sclk,
   output logic                    din,
   output logic                    load
);

   localparam int unsigned     DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [2:0]      INIT_LAST  = 3'd4;
   localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);
   localparam logic [3:0]      SCAN_LIMIT = 4'(NUM_DIGITS - 1);

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_DIGITS = 2'd1;
   localparam logic [1:0] ST_IDLE   = 2'd2;

   // Each bit is a LOW then a HIGH half; the two GAP halves hold load high to latch the frame.
   localparam logic [1:0] PH_LOW  = 2'd0;
   localparam logic [1:0] PH_HIGH = 2'd1;
   localparam logic [1:0] PH_GAP0 = 2'd2;
   localparam logic [1:0] PH_GAP1 = 2'd3;

   if (CLK_DIV < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_CYCLES < 2) begin : g_bad_params
      $error("max7219_driver: illegal parameter value");
   end

   logic [1:0]       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic             busy_q, busy_d;
   logic [1:0]       phase_q, phase_d;
   logic [3:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       snap_q [NUM_DIGITS];
   logic [7:0]       snap_d [NUM_DIGITS];
   logic             sclk_q, sclk_d;
   logic             din_q, din_d;
   logic             load_q, load_d;
   logic             ready_q, ready_d;

   logic             start_frame;
   logic             frame_done;
   logic             shifting_d;
   logic [15:0]      word_d;
   logic [7:0]       dig_byte [NUM_DIGITS];

`ifdef MAX7219_REFRESH_EN
   localparam int unsigned      IDLE_W    = $clog2(REFRESH_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES - 1);
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

   // Register data byte: D7=dp, D6..D0 = ~A..~G (input is active-low GFEDCBA).
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_map
      assign dig_byte[gi] = {dp_in[gi],
                             ~seg_in[7*gi+0], ~seg_in[7*gi+1], ~seg_in[7*gi+2],
                             ~seg_in[7*gi+3], ~seg_in[7*gi+4], ~seg_in[7*gi+5],
                             ~seg_in[7*gi+6]};
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      busy_d      = busy_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      div_d       = div_q;
      snap_d      = snap_q;
      start_frame = 1'b0;
      frame_done  = 1'b0;
`ifdef MAX7219_REFRESH_EN
      idle_cnt_d  = '0;
`endif

      if (busy_q) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            case (phase_q)
               PH_LOW:  phase_d = PH_HIGH;
               PH_HIGH: begin
                  if (bit_q == 4'd0) begin
                     phase_d = PH_GAP0;
                  end else begin
                     phase_d = PH_LOW;
                     bit_d   = bit_q - 4'd1;
                  end
               end
               PH_GAP0: phase_d = PH_GAP1;
               default: frame_done = 1'b1;
            endcase
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end

      // Sequencing decisions happen only between frames, so the next frame follows with no dead cycle.
      if (!busy_q || frame_done) begin
         case (state_q)
            ST_INIT: begin
               start_frame = 1'b1;
               if (busy_q) begin
                  if (idx_q == INIT_LAST) begin
                     state_d = ST_DIGITS;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
            ST_DIGITS: begin
               if (!busy_q) begin
                  start_frame = 1'b1;
               end else if (idx_q == DIGIT_LAST) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  idx_d       = idx_q + 3'd1;
                  start_frame = 1'b1;
               end
            end
            default: begin
               if (update) begin
                  snap_d      = dig_byte;
                  state_d     = ST_DIGITS;
                  idx_d       = '0;
                  start_frame = 1'b1;
               end
`ifdef MAX7219_REFRESH_EN
               else if (idle_cnt_q == IDLE_LAST) begin
                  state_d     = ST_INIT;
                  idx_d       = '0;
                  start_frame = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               end
`endif
            end
         endcase
      end

      if (start_frame) begin
         busy_d  = 1'b1;
         phase_d = PH_LOW;
         bit_d   = 4'd15;
         div_d   = '0;
      end
   end

   always_comb begin
      word_d = 16'h0000;
      if (state_d == ST_INIT) begin
         case (idx_d)
            3'd0:    word_d = 16'h0F00;
            3'd1:    word_d = 16'h0900;
            3'd2:    word_d = {8'h0A, 4'h0, INTENSITY};
            3'd3:    word_d = {8'h0B, 4'h0, SCAN_LIMIT};
            default: word_d = 16'h0C01;
         endcase
      end else begin
         word_d = {4'h0, {1'b0, idx_d} + 4'd1, snap_d[idx_d]};
      end
   end

   // Pins are registered from next-state so they come straight off flops.
   always_comb begin
      shifting_d = busy_d && (phase_d == PH_LOW || phase_d == PH_HIGH);
      load_d     = !shifting_d;
      sclk_d     = busy_d && (phase_d == PH_HIGH);
      din_d      = shifting_d && word_d[bit_d];
      ready_d    = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         phase_q <= PH_LOW;
         bit_q   <= '0;
         div_q   <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            snap_q[i] <= 8'h00;
         end
         sclk_q  <= 1'b0;
         din_q   <= 1'b0;
         load_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         snap_q  <= snap_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         load_q  <= load_d;
         ready_q <= ready_d;
      end
   end

`ifdef MAX7219_REFRESH_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`endif

   assign ready = ready_q;
   assign sclk  = sclk_q;
   assign din   = din_q;
   assign load  = load_q;

endmodule

// File: tb/tb_max7219_driver.sv
// Bench for max7219_driver: frame-queue reference model checked every cycle, plus an SPI receiver on the pins.
`timescale 1ns/1ps
module tb_max7219_driver;

   localparam int         CD       = 2;
   localparam int         ND       = 8;
   localparam int         RC       = 100;
   localparam logic [3:0] INTENS   = 4'h8;
   localparam int         FRAME    = 34 * CD;
   localparam int         BITS_END = 32 * CD;

   logic            clk = 1'b0;
   logic            rst;
   logic            update;
   logic [7*ND-1:0] seg_in;
   logic [ND-1:0]   dp_in;
   logic            ready, sclk, din, load;

   max7219_driver #(
      .CLK_DIV(CD), .NUM_DIGITS(ND), .INTENSITY(INTENS), .REFRESH_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .update(update),
      .ready(ready), .sclk(sclk), .din(din), .load(load)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Display byte from the segment rules: dp on D7, segment A on D6 down to G on D0, lit = 1.
   function automatic logic [7:0] seg_to_data(input logic [6:0] s, input logic dp);
      logic [7:0] d;
      d[7] = dp;
      for (int k = 0; k < 7; k++) d[6-k] = ~s[k];
      return d;
   endfunction

   // ---------------- reference model: queue of frames, time within current frame ----------------
   logic [15:0] m_q[$];
   logic [15:0] m_word;
   logic [7:0]  m_snap [ND];
   bit          m_pre = 1'b1;
   bit          m_busy = 1'b0;
   bit          m_idle = 1'b0;
   int          m_t = 0;
   int          m_idle_cnt = 0;

   function automatic void push_init();
      m_q.push_back(16'h0F00);
      m_q.push_back(16'h0900);
      m_q.push_back(16'h0A00 | 16'(INTENS));
      m_q.push_back(16'h0B00 | 16'(ND - 1));
      m_q.push_back(16'h0C01);
   endfunction

   function automatic void push_digits();
      for (int n = 0; n < ND; n++) m_q.push_back({4'h0, 4'(n + 1), m_snap[n]});
   endfunction

   function automatic void start_next();
      m_word = m_q.pop_front();
      m_t    = 0;
      m_busy = 1'b1;
      m_idle = 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_pre = 1'b1; m_busy = 1'b0; m_idle = 1'b0; m_t = 0; m_idle_cnt = 0;
         for (int i = 0; i < ND; i++) m_snap[i] = 8'h00;
      end else if (m_pre) begin
         m_pre = 1'b0;
         push_init();
         push_digits();
         start_next();
      end else if (m_busy) begin
         m_t++;
         if (m_t == FRAME) begin
            if (m_q.size() > 0) start_next();
            else begin
               m_busy = 1'b0; m_idle = 1'b1; m_idle_cnt = 0;
            end
         end
      end else if (m_idle) begin
         if (update) begin
            for (int n = 0; n < ND; n++) m_snap[n] = seg_to_data(seg_in[7*n +: 7], dp_in[n]);
            push_digits();
            start_next();
         end
`ifdef MAX7219_REFRESH_EN
         else if (m_idle_cnt == RC - 1) begin
            push_init();
            push_digits();
            start_next();
         end else begin
            m_idle_cnt++;
         end
`endif
      end
   end

   always @(negedge clk) begin
      if (rst || m_pre) begin
         check("rst_load", load, 1);
         check("rst_sclk", sclk, 0);
         check("rst_din", din, 0);
         check("rst_ready", ready, 0);
      end else if (m_busy) begin
         check("busy_ready", ready, 0);
         if (m_t < BITS_END) begin
            check("bit_load", load, 0);
            check("bit_sclk", sclk, 32'((m_t % (2 * CD)) >= CD));
            check("bit_din", din, 32'(m_word[15 - m_t / (2 * CD)]));
         end else begin
            check("gap_load", load, 1);
            check("gap_sclk", sclk, 0);
         end
      end else begin
         check("idle_load", load, 1);
         check("idle_sclk", sclk, 0);
         check("idle_ready", ready, 32'(m_idle));
      end
   end

   // ---------------- pin-level receiver: what a MAX7219 would latch ----------------
   logic [15:0] rx_sh = 16'h0;
   int          rx_cnt = 0;
   logic [15:0] rx_q[$];
   logic [15:0] exp_q[$];

   always @(negedge load) rx_cnt = 0;
   always @(posedge sclk) if (load === 1'b0) begin rx_sh = {rx_sh[14:0], din}; rx_cnt++; end
   always @(posedge load) if (rx_cnt == 16) rx_q.push_back(rx_sh);

   task automatic check_frames(input string name);
      check(name, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check(name, 32'(rx_q[i]), 32'(exp_q[i]));
   endtask

   task automatic wait_ready(input int limit, input string name);
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if (ready === 1'b1) break;
         k++;
         if (k >= limit) begin
            check(name, 32'(ready), 1);
            break;
         end
      end
   endtask

   task automatic pulse_update();
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic digit_exp_from_inputs();
      exp_q.delete();
      for (int n = 0; n < ND; n++) exp_q.push_back({4'h0, 4'(n + 1), seg_to_data(seg_in[7*n +: 7], dp_in[n])});
   endtask

   task automatic init_blank_exp();
      exp_q = '{16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01,
                16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int k;
      rst = 1'b1; update = 1'b0; seg_in = '0; dp_in = '0;
      repeat (3) @(negedge clk);
      check("reset_load", load, 1);
      check("reset_sclk", sclk, 0);
      check("reset_ready", ready, 0);

      // Power-up: init commands, blank digits, ready 13 frames after the first edge out of reset.
      rx_q.delete();
      rst = 1'b0;
      c0 = cyc;
      wait_ready(2000, "init_ready_timeout");
      check("ready_latency", 32'(cyc - c0 - 1), 32'(13 * 68));
      init_blank_exp();
      check_frames("init_frames");

      // Directed digit update.
      rx_q.delete();
      seg_in = '0;
      seg_in[6:0]  = 7'b100_0000;
      seg_in[13:7] = 7'b111_1001;
      dp_in = 8'b0000_0010;
      pulse_update();
      seg_in = 56'({$urandom(), $urandom()});
      dp_in  = 8'($urandom());
      wait_ready(1000, "update_ready_timeout");
      exp_q = '{16'h017E, 16'h02B0, 16'h037F, 16'h047F, 16'h057F, 16'h067F, 16'h077F, 16'h087F};
      check_frames("update_frames");

      // Randomised sets, some with updates pulsed while busy.
      for (int r = 0; r < 6; r++) begin
         rx_q.delete();
         seg_in = 56'({$urandom(), $urandom()});
         dp_in  = 8'($urandom());
         digit_exp_from_inputs();
         pulse_update();
         if (r % 2 == 0) begin
            repeat ($urandom_range(5, 200)) @(negedge clk);
            seg_in = 56'({$urandom(), $urandom()});
            dp_in  = 8'($urandom());
            check("busy_not_ready", ready, 0);
            pulse_update();
         end
         wait_ready(1000, "rand_ready_timeout");
         repeat ($urandom_range(2, 20)) @(negedge clk);
         check_frames("rand_frames");
      end

      // Reset in the middle of bit 7 of the first digit frame.
      seg_in = '0;
      dp_in  = 8'h01;
      update = 1'b1;
      @(posedge clk);
      #1 update = 1'b0;
      k = 0;
      forever begin
         if (rx_cnt == 8 && load === 1'b0 && sclk === 1'b0) break;
         k++;
         if (k > 200) begin
            check("bit7_search_timeout", 0, 1);
            break;
         end
         @(posedge clk);
         #1;
      end
      check("bit7_din", din, 1);
      #2 rst = 1'b1;
      #1;
      check("async_sclk", sclk, 0);
      check("async_load", load, 1);
      check("async_din", din, 0);
      check("async_ready", ready, 0);
      repeat (3) @(negedge clk);
      rx_q.delete();
      rst = 1'b0;
      wait_ready(2000, "restart_ready_timeout");
      init_blank_exp();
      check_frames("restart_frames");

`ifdef MAX7219_REFRESH_EN
      // Idle expiry resends init plus the held snapshot.
      seg_in = '0;
      seg_in[6:0]  = 7'b100_0000;
      seg_in[13:7] = 7'b111_1001;
      dp_in = 8'b0000_0010;
      pulse_update();
      wait_ready(1000, "refresh_pre_timeout");
      rx_q.delete();
      k = 0;
      forever begin
         @(negedge clk);
         k++;
         if (load === 1'b0 || k > 3 * RC) break;
      end
      check("refresh_delay", 32'(k), 32'(RC));
      wait_ready(2000, "refresh_ready_timeout");
      exp_q = '{16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01,
                16'h017E, 16'h02B0, 16'h037F, 16'h047F, 16'h057F, 16'h067F, 16'h077F, 16'h087F};
      check_frames("refresh_frames");

      // Update on the expiry edge: digits only.
      rx_q.delete();
      repeat (RC - 1) @(negedge clk);
      seg_in = 56'({$urandom(), $urandom()});
      dp_in  = 8'($urandom());
      digit_exp_from_inputs();
      pulse_update();
      wait_ready(1000, "expiry_ready_timeout");
      check_frames("expiry_frames");
`else
      // Without the refresh option the driver stays idle.
      rx_q.delete();
      repeat (3 * RC) @(negedge clk);
      check("no_refresh_frames", 32'(rx_q.size()), 0);
      check("no_refresh_ready", ready, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
